prefetch_rb_drain: RTL and testbench
====================================

# prefetch_rb_drain

Consumer for the BRAM prefetch ring buffer. It pulls entries from the ring buffer's read port (`rd_data`/`rd_en`/`occup`) and presents them as a registered valid/ready stream. It splits the stream into bursts with an `out_last` marker: a burst ends at `MAX_BURST` entries, or earlier when the ring buffer drains. It sits between a descriptor ring buffer and the DMA/packet-generation logic that consumes descriptors in bursts.

## Interface
- `DWIDTH`, no default: entry width; must match the ring buffer's `DWIDTH`.
- `AWIDTH`, no default: width of the ring buffer occupancy (`$clog2(DEPTH)`).
- `MAX_BURST`, 8: maximum entries per burst, 1..255.
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rb_rd_data`  in  `DWIDTH`  ring buffer head entry; valid whenever the ring buffer is non-empty.
- `rb_rd_en`  out  1  consume the head entry this cycle.
- `rb_occup`  in  `AWIDTH`  ring buffer occupancy, already net of this cycle's `rb_rd_en`.
- `out_data`  out  `DWIDTH`  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_last`  out  1  last entry of the current burst.
- `out_cnt`  out  32  total entries accepted downstream; wraps at 2^32.

## Operation
- **avail_r** (`AWIDTH` bits) is a lower bound on the ring buffer's real occupancy.
  - Updated every cycle: `avail_r <= rb_occup`.
  - It is conservative because `rb_occup` already subtracts the current read, and writes only increase the real occupancy.
  - `rb_rd_en` must never depend combinationally on `rb_occup`, because `rb_occup` depends on `rb_rd_en` and that would form a loop.
- **rb_rd_en** = `(avail_r != 0) && (fifo_cnt < 2)`.
  - Purely registered terms; no combinational path from `out_ready`.
- **Output FIFO**: 2 entries of {`data`, `last`}, registered.
  - On `rb_rd_en`, `rb_rd_data` is written at the tail on the same edge.
  - `fifo_cnt` (2 bits) is incremented by `rb_rd_en` and decremented by `out_valid && out_ready`.
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - `out_data`/`out_last` always show the head entry; `out_valid = (fifo_cnt != 0)`.
- **Burst tagging** uses `burst_cnt` (8 bits), advanced at read time.
  - The `last` bit stored with the entry = `(burst_cnt == MAX_BURST-1) || (rb_occup == 0)`.
  - `rb_occup == 0` in the read cycle means the ring buffer is empty after this consume.
  - On a read with `last`=1, `burst_cnt <= 0`; on a read with `last`=0, `burst_cnt <= burst_cnt + 1`.
  - With `MAX_BURST`=1, every entry carries `last`.
- **out_cnt** increments on each `out_valid && out_ready`, wrapping modulo 2^32.
- **Ordering**: entries leave in exactly ring buffer order. No drops; no duplicates.

## Timing
- **Reset** (`rst_n`=0 sampled on a `clk` edge) clears:
  - `avail_r`, `fifo_cnt`, `burst_cnt`, `out_cnt`, FIFO pointers → 0.
  - Outputs: `out_valid`=0, `out_last`=0, `out_data`=0, `out_cnt`=0, `rb_rd_en`=0.
- **First cycle after reset**: `rb_rd_en`=0, because `avail_r`=0.
- **Reset mid-operation**: FIFO contents and the partial burst are discarded, and the next burst starts at `burst_cnt`=0. The ring buffer is reset alongside by the system.
- **Latency, first write into an empty ring buffer**:
  - Cycle N: the entry is written into the ring buffer.
  - Cycle N+1: `rb_occup` shows 1.
  - Cycle N+2: `avail_r`=1 and `rb_rd_en`=1.
  - Cycle N+3: `out_valid`=1.
- **Throughput**: with `out_ready` held at 1 and `avail_r`>0, there is one read and one output per cycle and `fifo_cnt` holds at 1.
- **Backpressure**:
  - With `out_ready`=0, at most 2 entries are read past the stall; `rb_rd_en`=0 while `fifo_cnt`=2.
  - Once `out_ready` returns, the first read resumes one cycle after the pop.
- **Stream rules**: `out_data`/`out_last` are stable while `out_valid && !out_ready`. `out_valid` never drops without a handshake, except at reset.
- **Empty ring buffer**: if `avail_r`=0, no read happens even if a write lands that cycle; the read is picked up on the next cycle.
- **Wrap-around**: the ring buffer handles pointer wrap; this block sees only occupancy. `burst_cnt` wraps only via `last`.

## Test plan
- **Reset values**: hold `rst_n`=0 for 3 cycles with `rb_occup`=5.
  - Required: `out_valid`=0, `rb_rd_en`=0, `out_cnt`=0 throughout and in the first cycle after release.
  - Required: `rb_rd_en`=1 on the second cycle after release.
- **Single entry**: write 0xA5 into an empty ring buffer with `out_ready`=1.
  - Required: `out_valid` rises 3 cycles after the write, with `out_data`=0xA5, `out_last`=1 (ring buffer drained), `out_cnt` 0→1.
- **Burst split**: `MAX_BURST`=8; preload 20 entries 0..19; `out_ready`=1.
  - Required: 20 back-to-back outputs in order.
  - Required: `out_last` on entries 7 and 15, plus on 19 (drain).
- **Backpressure**: preload 10 entries; `out_ready`=0 for 6 cycles, then 1.
  - Required: exactly 2 reads during the stall; data held stable; all 10 delivered in order.
  - Required: `out_last` only on entries 7 and 9.
- **Random stress**: random writes (≤1/cycle, ring buffer never full) and random `out_ready`.
  - Required: the scoreboard sees identical ordering, no loss and no duplicates.
  - Required: every `out_last` matches the `MAX_BURST`/drain rule.
  - Required: `out_cnt` equals the number of handshakes.
- **Mid-burst reset**: pulse `rst_n` low for 1 cycle while `fifo_cnt`=2 and `burst_cnt`=3.
  - Required: `out_valid`=0 the next cycle and `out_cnt`=0.
  - Required: the next burst's `last` falls on its 8th entry.

Source files
------------

// File: rtl/prefetch_rb_drain.sv
// prefetch_rb_drain: drains the BRAM prefetch ring buffer into a registered valid/ready stream
// and tags burst boundaries with out_last.
//
// Ports:
//   clk         single clock
//   rst_n       synchronous active-low reset
//   rb_rd_data  ring buffer head entry (valid while the ring buffer is non-empty)
//   rb_rd_en    consume the head entry this cycle
//   rb_occup    ring buffer occupancy, already net of this cycle's rb_rd_en
//   out_data    stream data (head of the 2-entry output FIFO)
//   out_valid   stream valid
//   out_ready   stream ready
//   out_last    last entry of the current burst
//   out_cnt     total entries accepted downstream, wraps at 2^32
`timescale 1ns/1ps
module prefetch_rb_drain #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned AWIDTH    = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] rb_rd_data,
  output logic              rb_rd_en,
  input  logic [AWIDTH-1:0] rb_occup,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [31:0]       out_cnt
);

  localparam logic [7:0] LastIdx = 8'(MAX_BURST - 1);

  // Registered copy of rb_occup: a lower bound on the real occupancy that lets rb_rd_en
  // avoid a combinational loop through the ring buffer's occupancy logic.
  logic [AWIDTH-1:0] avail_q;

  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic              wr_ptr_q, rd_ptr_q;
  logic [DWIDTH-1:0] mem_data_q [2];
  logic [1:0]        mem_last_q;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic [31:0]       out_cnt_q;

  logic push, pop, entry_last;

  always_comb begin
    push        = (avail_q != '0) && (fifo_cnt_q < 2'd2);
    pop         = (fifo_cnt_q != 2'd0) && out_ready;
    // rb_occup == 0 during a read means this read empties the ring buffer.
    entry_last  = (burst_cnt_q == LastIdx) || (rb_occup == '0);
    fifo_cnt_d  = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    burst_cnt_d = burst_cnt_q;
    if (push) begin
      burst_cnt_d = entry_last ? 8'd0 : burst_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avail_q       <= '0;
      fifo_cnt_q    <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      mem_data_q[0] <= '0;
      mem_data_q[1] <= '0;
      mem_last_q    <= 2'b00;
      burst_cnt_q   <= 8'd0;
      out_cnt_q     <= 32'd0;
    end else begin
      avail_q     <= rb_occup;
      fifo_cnt_q  <= fifo_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      if (push) begin
        mem_data_q[wr_ptr_q] <= rb_rd_data;
        mem_last_q[wr_ptr_q] <= entry_last;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        out_cnt_q <= out_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    rb_rd_en  = push;
    out_valid = (fifo_cnt_q != 2'd0);
    out_data  = mem_data_q[rd_ptr_q];
    out_last  = mem_last_q[rd_ptr_q];
    out_cnt   = out_cnt_q;
  end

endmodule

// File: tb/tb_prefetch_rb_drain.sv
// Testbench for prefetch_rb_drain: a ring buffer environment feeds the DUT; a queue-based model
// of in-flight entries is compared every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_prefetch_rb_drain;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int MB = 8;
  localparam int RbSize = 4096;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] rb_rd_data;
  logic          rb_rd_en;
  logic [AW-1:0] rb_occup;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [31:0]   out_cnt;

  prefetch_rb_drain #(
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .MAX_BURST(MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rb_rd_data(rb_rd_data),
    .rb_rd_en  (rb_rd_en),
    .rb_occup  (rb_occup),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ring buffer environment ----------------
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rb_flush;
  logic [DW-1:0] rb_mem [RbSize];
  int unsigned   rb_wp = 0;
  int unsigned   rb_rp = 0;
  int            rb_count;

  initial for (int i = 0; i < RbSize; i++) rb_mem[i] = '0;

  always @(posedge clk) begin
    if (rb_flush) begin
      rb_rp <= rb_wp;
    end else begin
      if (rb_rd_en) rb_rp <= rb_rp + 1;
      if (wr_en) begin
        rb_mem[rb_wp % RbSize] <= wr_data;
        rb_wp <= rb_wp + 1;
      end
    end
  end

  assign rb_count   = int'(rb_wp - rb_rp);
  assign rb_occup   = AW'(rb_count - (rb_rd_en ? 1 : 0));
  assign rb_rd_data = rb_mem[rb_rp % RbSize];

  // ---------------- checking ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: entries read from the ring buffer but not yet handed downstream, in order.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } ent_t;

  ent_t        exp_q[$];
  int          burst_pos = 0;
  logic [31:0] hs_count  = '0;
  int          avail_m   = 0;
  bit          primed    = 0;
  logic        m_last;

  always @(negedge clk) begin
    if (primed) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("rb_rd_en", 64'(rb_rd_en), 64'((avail_m != 0) && (exp_q.size() < 2)));
      check("out_cnt", 64'(out_cnt), 64'(hs_count));
      if (exp_q.size() != 0) begin
        check("out_data", 64'(out_data), 64'(exp_q[0].data));
        check("out_last", 64'(out_last), 64'(exp_q[0].last));
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      burst_pos = 0;
      hs_count  = '0;
      avail_m   = 0;
      primed    = 1;
    end else if (primed) begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        hs_count = hs_count + 32'd1;
      end
      if (rb_rd_en) begin
        // A burst closes at MB entries or when this read leaves the ring buffer empty.
        m_last = (burst_pos == MB - 1) || (rb_count == 1);
        exp_q.push_back('{data: rb_rd_data, last: m_last});
        burst_pos = m_last ? 0 : burst_pos + 1;
      end
      avail_m = rb_count - (rb_rd_en ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends at the drive point of the first cycle after reset release.
  task automatic reset_preload(input int n, input int base);
    rst_n    = 1'b0;
    rb_flush = 1'b1;
    wr_en    = 1'b0;
    tick();
    rb_flush = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(base + i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic collect(input int n, input int base, input int budget,
                         output logic [31:0] mask, output int first_cyc, output int last_cyc,
                         output int first_rd);
    int got;
    mask      = '0;
    got       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    first_rd  = -1;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (rb_rd_en && first_rd < 0) first_rd = cyc;
      if (out_valid && out_ready) begin
        check("order", 64'(out_data), 64'(DW'(base + got)));
        mask[got] = out_last;
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      @(posedge clk);
      #1;
    end
    check("delivered", 64'(got), 64'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] mask;
  int          fc, lc, frd, r1, wr_cyc, rise, reads, seq, rx, bad, wr_pct, rdy_pct;

  initial begin
    rst_n     = 1'b0;
    rb_flush  = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    out_ready = 1'b1;

    // Reset values: rb_occup = 5 while reset is held for 3 cycles.
    tick();
    rb_flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(16'h0100 + i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_rd_en", 64'(rb_rd_en), 64'(0));
      check("rst_cnt", 64'(out_cnt), 64'(0));
      check("rst_data", 64'(out_data), 64'(0));
      check("rst_last", 64'(out_last), 64'(0));
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rel1_rd_en", 64'(rb_rd_en), 64'(0));
    check("rel1_valid", 64'(out_valid), 64'(0));
    check("rel1_cnt", 64'(out_cnt), 64'(0));
    tick();
    @(negedge clk);
    check("rel2_rd_en", 64'(rb_rd_en), 64'(1));
    repeat (10) tick();

    // Single entry into an empty ring buffer.
    out_ready = 1'b1;
    reset_preload(0, 0);
    repeat (3) tick();
    wr_en   = 1'b1;
    wr_data = 16'h00A5;
    wr_cyc  = cyc;
    tick();
    wr_en = 1'b0;
    rise  = -1;
    for (int c = 0; c < 10 && rise < 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        rise = cyc;
        check("single_data", 64'(out_data), 64'(16'h00A5));
        check("single_last", 64'(out_last), 64'(1));
        check("single_cnt0", 64'(out_cnt), 64'(0));
      end
      tick();
    end
    check("single_latency", 64'(rise - wr_cyc), 64'(3));
    @(negedge clk);
    check("single_cnt1", 64'(out_cnt), 64'(1));
    tick();

    // Burst split: 20 preloaded entries, MAX_BURST = 8.
    out_ready = 1'b1;
    reset_preload(20, 0);
    r1 = cyc;
    collect(20, 0, 40, mask, fc, lc, frd);
    check("burst_first", 64'(fc - r1), 64'(2));
    check("burst_b2b", 64'(lc - fc), 64'(19));
    check("burst_mask", 64'(mask), 64'(32'h0008_8080));

    // Backpressure: 10 entries, out_ready low for 6 cycles.
    out_ready = 1'b0;
    reset_preload(10, 16'h0200);
    reads = 0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      if (rb_rd_en) reads++;
      if (s >= 2) begin
        check("bp_hold_valid", 64'(out_valid), 64'(1));
        check("bp_hold_data", 64'(out_data), 64'(16'h0200));
      end
      tick();
    end
    check("bp_reads", 64'(reads), 64'(2));
    out_ready = 1'b1;
    collect(10, 16'h0200, 40, mask, fc, lc, frd);
    check("bp_resume", 64'(frd - fc), 64'(1));
    check("bp_mask", 64'(mask), 64'(32'h0000_0280));

    // Random stress; the per-cycle model checks every last bit and count.
    seq = 0;
    rx  = 0;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      case (i / 500)
        0:       begin wr_pct = 30; rdy_pct = 90; end
        1:       begin wr_pct = 70; rdy_pct = 40; end
        2:       begin wr_pct = 95; rdy_pct = 95; end
        3:       begin wr_pct = 50; rdy_pct = 20; end
        4:       begin wr_pct = 10; rdy_pct = 70; end
        default: begin wr_pct = 60; rdy_pct = 60; end
      endcase
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (rb_count < 60 && $urandom_range(0, 99) < wr_pct) begin
        wr_en   = 1'b1;
        wr_data = DW'(16'h1000 + seq);
        seq++;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (out_data !== DW'(16'h1000 + rx)) bad++;
        rx++;
      end
      tick();
    end
    wr_en     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (out_data !== DW'(16'h1000 + rx)) bad++;
        rx++;
      end
      if (rb_count == 0 && !out_valid && !rb_rd_en) break;
      tick();
    end
    tick();
    check("stress_order", 64'(bad), 64'(0));
    check("stress_count", 64'(rx), 64'(seq));
    check("stress_out_cnt", 64'(out_cnt), 64'(10 + rx));

    // Mid-burst reset with two entries buffered and burst position 3.
    out_ready = 1'b0;
    reset_preload(10, 16'h0300);
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    rst_n    = 1'b0;
    rb_flush = 1'b1;
    tick();
    rst_n    = 1'b1;
    rb_flush = 1'b0;
    @(negedge clk);
    check("mid_valid", 64'(out_valid), 64'(0));
    check("mid_cnt", 64'(out_cnt), 64'(0));
    tick();
    for (int i = 0; i < 12; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(16'h0400 + i);
      tick();
    end
    wr_en     = 1'b0;
    out_ready = 1'b1;
    collect(12, 16'h0400, 60, mask, fc, lc, frd);
    check("mid_mask", 64'(mask), 64'(32'h0000_0880));
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
